// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: fetch FSM encoding, fetch packet type and the
// branch/ALU codes used by execute.
package rv_core_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Branch condition codes decoded in execute.
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;
  localparam logic [2:0] BR_JAL  = 3'd7;

  localparam logic [3:0] ALU_JALR = 4'd10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  // Sequential PC advance; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: owns the PC, keeps one imem read outstanding and
// hands {pc, instr} to decode. Optional trap on misaligned jump: IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic        if_misaligned
`endif
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        if_valid_q, if_valid_d;
  fetch_pkt_t  pkt_q, pkt_d;
  logic [31:0] redirect_pc;
  logic        in_flight;

`ifdef IFU_MISALIGN_TRAP_EN
  logic        misaligned_q, misaligned_d;
  logic        target_misaligned;

  assign redirect_pc       = jump_target;
  assign target_misaligned = |jump_target[1:0];
  // A halted fetch can still have a dropped read outstanding until its response shows up.
  assign in_flight = (state_q == S_REQ  && imem_req_ready) ||
                     (state_q == S_WAIT && !imem_rsp_valid) ||
                     (state_q == S_HALT && drop_q && !imem_rsp_valid);
`else
  assign redirect_pc = jump_target & ~32'h3;
  assign in_flight   = (state_q == S_REQ  && imem_req_ready) ||
                       (state_q == S_WAIT && !imem_rsp_valid);
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    pkt_d      = pkt_q;
`ifdef IFU_MISALIGN_TRAP_EN
    misaligned_d = misaligned_q;
`endif

    if (jump_flag) begin
      // Redirect beats any response or decode handshake in the same cycle.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      drop_d     = in_flight;
      state_d    = in_flight ? S_WAIT : S_REQ;
`ifdef IFU_MISALIGN_TRAP_EN
      misaligned_d = target_misaligned;
      if (target_misaligned) begin
        state_d = S_HALT;
      end
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              pkt_d      = '{pc: pc_q, instr: imem_rsp_data};
              if_valid_d = 1'b1;
              pc_d       = pc_inc(pc_q);
              state_d    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (if_ready) begin
            if_valid_d = 1'b0;
            state_d    = S_REQ;
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        S_HALT: begin
          if (imem_rsp_valid) begin
            drop_d = 1'b0;
          end
        end
`endif
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_VECTOR;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      pkt_q      <= '{pc: 32'h0, instr: INSTR_NOP};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      pkt_q      <= pkt_d;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign if_misaligned = misaligned_q;
`endif

  // The request line is forced low while reset is held, even though the FSM sits in S_REQ.
  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = pkt_q.pc;
  assign if_instr       = pkt_q.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural imem plus a
// transaction-level PC-stream model, directed scenarios and a randomized run.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        if_misaligned;
`endif

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_flag      (jump_flag),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .if_misaligned  (if_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: next PC that decode must see, and trap state.
  logic [31:0] exp_pc   = 32'h0;
  bit          exp_halt = 1'b0;

  // Instruction memory model: one read tracked, fixed content per address.
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_wait = 0;
  int          ready_mode = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          spurious_en = 1'b0;

  int          tick_no = 0;
  int          first_valid_t = -1;
  logic [31:0] acc_q[$];
  int          acc_t[$];
  logic [31:0] hs_q[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: memory drives, model scores the pre-edge view, clock advances.
  task automatic tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_busy) begin
      mem_wait--;
      if (mem_wait <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem_addr);
        mem_busy       = 1'b0;
      end
    end else if (spurious_en && $urandom_range(0, 7) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    case (ready_mode)
      0:       imem_req_ready = 1'b0;
      1:       imem_req_ready = 1'b1;
      default: imem_req_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
`ifdef IFU_MISALIGN_TRAP_EN
    chk_cnt++;
    if (if_misaligned !== 1'(exp_halt))
      $display("FAIL misaligned_flag: got %b expected %b (tick %0d)", if_misaligned, exp_halt, tick_no);
    else pass_cnt++;
`endif
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      chk_cnt++;
      if (mem_busy || exp_halt)
        $display("FAIL one_outstanding: request accepted with busy=%b halt=%b (tick %0d)", mem_busy, exp_halt, tick_no);
      else pass_cnt++;
      chk_cnt++;
      if (imem_addr !== exp_pc)
        $display("FAIL fetch_addr: got %h expected %h (tick %0d)", imem_addr, exp_pc, tick_no);
      else pass_cnt++;
      acc_q.push_back(imem_addr);
      acc_t.push_back(tick_no);
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_wait = $urandom_range(lat_min, lat_max);
    end
    if (if_valid === 1'b1 && first_valid_t < 0) first_valid_t = tick_no;
    if (jump_flag) begin
`ifdef IFU_MISALIGN_TRAP_EN
      exp_halt = |jump_target[1:0];
      exp_pc   = jump_target;
`else
      exp_pc   = {jump_target[31:2], 2'b00};
`endif
    end else if (if_valid === 1'b1 && if_ready) begin
      chk_cnt++;
      if (if_pc !== exp_pc)
        $display("FAIL handshake_pc: got %h expected %h (tick %0d)", if_pc, exp_pc, tick_no);
      else pass_cnt++;
      chk_cnt++;
      if (if_instr !== instr_of(if_pc))
        $display("FAIL handshake_instr: got %h expected %h (pc %h)", if_instr, instr_of(if_pc), if_pc);
      else pass_cnt++;
      hs_q.push_back(if_pc);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    tick_no++;
  endtask

  task automatic do_reset(input bit keep_mem);
    @(negedge clk);
    rst_n          = 1'b0;
    jump_flag      = 1'b0;
    jump_target    = 32'h0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_pc   = 32'h0;
    exp_halt = 1'b0;
    if (!keep_mem) mem_busy = 1'b0;
    acc_q.delete();
    acc_t.delete();
    hs_q.delete();
    first_valid_t = -1;
    tick_no = 0;
    spurious_en = 1'b0;
    lat_min = 1;
    lat_max = 1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
    else pass_cnt++;
    chk_cnt++;
    if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b expected 0", if_valid);
    else pass_cnt++;
    chk_cnt++;
    if (if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h expected 00000000", if_pc);
    else pass_cnt++;
    chk_cnt++;
    if (if_instr !== 32'h0000_0013) $display("FAIL reset_if_instr: got %h expected 00000013", if_instr);
    else pass_cnt++;
`ifdef IFU_MISALIGN_TRAP_EN
    chk_cnt++;
    if (if_misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b expected 0", if_misaligned);
    else pass_cnt++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_first_req: got valid=%b addr=%h expected valid=1 addr=00000000", imem_req_valid, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    do_reset(1'b0);
    ready_mode = 1;
    if_ready   = 1'b1;
    for (int n = 0; n < 60 && hs_q.size() < 3; n++) tick();
    chk_cnt++;
    if (hs_q.size() != 3 || acc_q.size() < 3)
      $display("FAIL seq_count: got %0d handshakes %0d reqs expected 3 and 3", hs_q.size(), acc_q.size());
    else pass_cnt++;
    if (hs_q.size() >= 3 && acc_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk_cnt++;
        if (acc_q[i] !== 32'(4 * i) || hs_q[i] !== 32'(4 * i))
          $display("FAIL seq_order: got addr=%h pc=%h expected %h", acc_q[i], hs_q[i], 32'(4 * i));
        else pass_cnt++;
      end
      chk_cnt++;
      if (first_valid_t - acc_t[0] != 2)
        $display("FAIL seq_latency: got %0d expected 2", first_valid_t - acc_t[0]);
      else pass_cnt++;
      chk_cnt++;
      if (acc_t[1] - acc_t[0] != 3)
        $display("FAIL seq_next_req: got %0d expected 3", acc_t[1] - acc_t[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    ready_mode = 1;
    if_ready   = 1'b1;
    for (int n = 0; n < 40 && hs_q.size() < 2; n++) tick();
    if_ready = 1'b0;
    for (int n = 0; n < 20 && if_valid !== 1'b1; n++) tick();
    chk_cnt++;
    if (if_valid !== 1'b1) $display("FAIL stall_reach: got if_valid=%b expected 1", if_valid);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== instr_of(32'h8))
        $display("FAIL stall_hold: got v=%b pc=%h instr=%h expected v=1 pc=00000008 instr=%h", if_valid, if_pc, if_instr, instr_of(32'h8));
      else pass_cnt++;
      chk_cnt++;
      if (imem_req_valid !== 1'b0) $display("FAIL stall_no_req: got %b expected 0", imem_req_valid);
      else pass_cnt++;
      tick();
    end
    if_ready = 1'b1;
    tick();
    chk_cnt++;
    if (hs_q.size() != 3 || hs_q[hs_q.size()-1] !== 32'h8)
      $display("FAIL stall_release: got %0d handshakes expected 3 ending at pc 00000008", hs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_jump_wait();
    do_reset(1'b0);
    ready_mode = 1;
    lat_min = 3;
    lat_max = 3;
    if_ready = 1'b1;
    for (int n = 0; n < 10 && acc_q.size() < 1; n++) tick();
    jump_flag   = 1'b1;
    jump_target = 32'h100;
    tick();
    jump_flag = 1'b0;
    for (int n = 0; n < 40 && hs_q.size() < 1; n++) tick();
    chk_cnt++;
    if (acc_q.size() < 2 || acc_q[1] !== 32'h100)
      $display("FAIL jump_wait_addr: got %0d reqs expected second at 00000100", acc_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (hs_q.size() < 1 || hs_q[0] !== 32'h100)
      $display("FAIL jump_wait_pc: got %0d handshakes expected first at 00000100", hs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_jump_collide();
    int h;
    do_reset(1'b0);
    ready_mode = 1;
    if_ready = 1'b1;
    for (int n = 0; n < 10 && acc_q.size() < 1; n++) tick();
    jump_flag   = 1'b1;
    jump_target = 32'h200;
    tick();
    jump_flag = 1'b0;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL collide_rsp: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000200", if_valid, imem_req_valid, imem_addr);
    else pass_cnt++;
    for (int n = 0; n < 20 && hs_q.size() < 1; n++) tick();
    chk_cnt++;
    if (hs_q.size() < 1 || hs_q[0] !== 32'h200)
      $display("FAIL collide_rsp_pc: got %0d handshakes expected first at 00000200", hs_q.size());
    else pass_cnt++;
    if_ready = 1'b0;
    for (int n = 0; n < 20 && if_valid !== 1'b1; n++) tick();
    h = hs_q.size();
    if_ready    = 1'b1;
    jump_flag   = 1'b1;
    jump_target = 32'h300;
    tick();
    jump_flag = 1'b0;
    chk_cnt++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h300)
      $display("FAIL collide_hold: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000300", if_valid, imem_req_valid, imem_addr);
    else pass_cnt++;
    for (int n = 0; n < 20 && hs_q.size() < h + 1; n++) tick();
    chk_cnt++;
    if (hs_q.size() < h + 1 || hs_q[h] !== 32'h300)
      $display("FAIL collide_hold_pc: got %0d handshakes expected next at 00000300", hs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    ready_mode  = 0;
    jump_flag   = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    jump_flag  = 1'b0;
    ready_mode = 1;
    if_ready   = 1'b1;
    for (int n = 0; n < 20 && acc_q.size() < 2; n++) tick();
    chk_cnt++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFFC || acc_q[1] !== 32'h0)
      $display("FAIL wrap_addr: got %0d reqs expected fffffffc then 00000000", acc_q.size());
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    do_reset(1'b0);
    ready_mode  = 0;
    jump_flag   = 1'b1;
    jump_target = 32'h102;
    tick();
    jump_flag  = 1'b0;
    ready_mode = 1;
    if_ready   = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      chk_cnt++;
      if (if_misaligned !== 1'b1 || imem_req_valid !== 1'b0)
        $display("FAIL misalign_halt: got mis=%b req=%b expected mis=1 req=0", if_misaligned, imem_req_valid);
      else pass_cnt++;
      tick();
    end
    jump_flag   = 1'b1;
    jump_target = 32'h200;
    tick();
    jump_flag = 1'b0;
    chk_cnt++;
    if (if_misaligned !== 1'b0) $display("FAIL misalign_clear: got %b expected 0", if_misaligned);
    else pass_cnt++;
    for (int n = 0; n < 10 && acc_q.size() < 1; n++) tick();
    chk_cnt++;
    if (acc_q.size() < 1 || acc_q[0] !== 32'h200)
      $display("FAIL misalign_resume: got %0d reqs expected first at 00000200", acc_q.size());
    else pass_cnt++;
`else
    for (int n = 0; n < 20 && hs_q.size() < 1; n++) tick();
    chk_cnt++;
    if (acc_q.size() < 1 || acc_q[0] !== 32'h100)
      $display("FAIL misalign_force: got %0d reqs expected first at 00000100", acc_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (hs_q.size() < 1 || hs_q[0] !== 32'h100)
      $display("FAIL misalign_force_pc: got %0d handshakes expected first at 00000100", hs_q.size());
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_midflight();
    do_reset(1'b0);
    ready_mode  = 0;
    jump_flag   = 1'b1;
    jump_target = 32'h400;
    tick();
    jump_flag  = 1'b0;
    ready_mode = 1;
    lat_min = 3;
    lat_max = 3;
    for (int n = 0; n < 10 && acc_q.size() < 1; n++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0)
      $display("FAIL midflight_clear: got req=%b v=%b pc=%h expected 0 0 00000000", imem_req_valid, if_valid, if_pc);
    else pass_cnt++;
    do_reset(1'b1);
    ready_mode = 0;
    for (int n = 0; n < 10 && mem_busy; n++) tick();
    ready_mode = 1;
    if_ready   = 1'b1;
    for (int n = 0; n < 20 && hs_q.size() < 1; n++) tick();
    chk_cnt++;
    if (acc_q.size() < 1 || hs_q.size() < 1 || acc_q[0] !== 32'h0 || hs_q[0] !== 32'h0)
      $display("FAIL midflight_restart: got %0d reqs %0d handshakes expected first at 00000000", acc_q.size(), hs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    ready_mode  = 2;
    lat_min     = 1;
    lat_max     = 3;
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if_ready    = ($urandom_range(0, 3) != 0);
      jump_flag   = ($urandom_range(0, 11) == 0);
      jump_target = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
      if ($urandom_range(0, 3) != 0) jump_target[1:0] = 2'b00;
`endif
      tick();
    end
    jump_flag   = 1'b0;
    spurious_en = 1'b0;
    chk_cnt++;
    if (hs_q.size() < 50) $display("FAIL random_progress: got %0d handshakes expected at least 50", hs_q.size());
    else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump_wait();
    test_jump_collide();
    test_wrap();
    test_misalign();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
